sprite_rom_arbiter: RTL and testbench

- Shares one single-port sprite ROM among several sprite renderers (ducks, dog, crosshair, HUD) with round-robin arbitration.
- Each ROM read is tagged so the returning 24-bit pixel is routed back to the requester that issued it.
- A transparency flag is raised when the returned pixel equals the colour key.
- Sits between the per-sprite draw engines and the ROM instance in the VGA pixel pipeline.

---
 rtl/sprite_rom_arbiter.sv | 149 ++++++++++++++
 tb/tb_sprite_rom_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
// Shares one single-port sprite ROM among NUM_REQ sprite renderers using
// round-robin arbitration. Each accepted fetch is tagged with the winner's
// index, and the tag travels alongside the ROM access so the returning pixel
// can be routed back to whoever asked for it. A transparency flag is raised
// when a returned pixel matches the colour key.
//
// Ports:
//   clk_i             system clock, rising edge
//   rst_i             asynchronous active-high reset
//   req_i             per-requester fetch request, sampled every edge
//   req_addr_i        flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt_o             one-hot grant, high the cycle after acceptance
//   rom_addr_o        registered ROM address
//   rom_data_i        ROM read data
//   rsp_valid_o       response valid
//   rsp_id_o          owner of the current response (0 when idle)
//   rsp_data_o        pixel, combinational pass-through of rom_data_i
//   rsp_transparent_o response valid and pixel equals KEY_COLOR
module sprite_rom_arbiter #(
    parameter int unsigned       NUM_REQ     = 4,
    parameter int unsigned       ADDR_W      = 19,
    parameter int unsigned       DATA_W      = 24,
    parameter int unsigned       ROM_LATENCY = 1,
    parameter logic [DATA_W-1:0] KEY_COLOR   = 24'hFF00FF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [ADDR_W-1:0]           rom_addr_o,
    input  logic [DATA_W-1:0]           rom_data_i,
    output logic                        rsp_valid_o,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id_o,
    output logic [DATA_W-1:0]           rsp_data_o,
    output logic                        rsp_transparent_o
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned IDX_W = ID_W + 1;

    // Arbitration state and issue stage
    logic [ID_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [NUM_REQ-1:0] gnt_q,       gnt_d;
    logic [ADDR_W-1:0]  rom_addr_q,  rom_addr_d;
    logic               iss_valid_q, iss_valid_d;
    logic [ID_W-1:0]    iss_tag_q,   iss_tag_d;

    // Response pipeline matching the ROM latency
    logic [ROM_LATENCY-1:0] pipe_valid_q;
    logic [ID_W-1:0]        pipe_tag_q [ROM_LATENCY];

    // Combinational arbitration results
    logic               any_req_c;
    logic [ID_W-1:0]    winner_c;
    logic [IDX_W-1:0]   idx_c;
    logic [ADDR_W-1:0]  addr_sel_c;

    // Round-robin search: first set request at or after rr_ptr, with wrap
    always_comb begin
        any_req_c = 1'b0;
        winner_c  = '0;
        idx_c     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx_c = {1'b0, rr_ptr_q} + IDX_W'(k);
            if (idx_c >= IDX_W'(NUM_REQ)) begin
                idx_c = idx_c - IDX_W'(NUM_REQ);
            end
            if (!any_req_c && req_i[idx_c[ID_W-1:0]]) begin
                any_req_c = 1'b1;
                winner_c  = idx_c[ID_W-1:0];
            end
        end
    end

    // Address mux for the winning requester
    always_comb begin
        addr_sel_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner_c == ID_W'(i)) begin
                addr_sel_c = req_addr_i[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next-state for grant, ROM address, pointer and issue stage
    always_comb begin
        gnt_d       = '0;
        rom_addr_d  = rom_addr_q;
        rr_ptr_d    = rr_ptr_q;
        iss_valid_d = 1'b0;
        iss_tag_d   = '0;
        if (any_req_c) begin
            gnt_d       = NUM_REQ'(1) << winner_c;
            rom_addr_d  = addr_sel_c;
            iss_valid_d = 1'b1;
            iss_tag_d   = winner_c;
            if (winner_c == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = winner_c + ID_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            rom_addr_q  <= '0;
            iss_valid_q <= 1'b0;
            iss_tag_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            rom_addr_q  <= rom_addr_d;
            iss_valid_q <= iss_valid_d;
            iss_tag_q   <= iss_tag_d;
        end
    end

    // Delay (valid, tag) by ROM_LATENCY edges so it lines up with rom_data_i
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_valid_q <= '0;
            for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= iss_valid_q;
            pipe_tag_q[0]   <= iss_tag_q;
            for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_tag_q[i]   <= pipe_tag_q[i-1];
            end
        end
    end

    assign gnt_o             = gnt_q;
    assign rom_addr_o        = rom_addr_q;
    assign rsp_valid_o       = pipe_valid_q[ROM_LATENCY-1];
    // Tag is forced to zero on idle issue, so the id reads 0 when no response
    assign rsp_id_o          = pipe_tag_q[ROM_LATENCY-1];
    assign rsp_data_o        = rom_data_i;
    assign rsp_transparent_o = rsp_valid_o && (rom_data_i == KEY_COLOR);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomised scoreboard bench for sprite_rom_arbiter.
module tb_sprite_rom_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned AW  = 19;
    localparam int unsigned DW  = 24;
    localparam int unsigned LAT = 1;
    localparam logic [DW-1:0] KEY = 24'hFF00FF;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N-1:0]      gnt;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data = '0;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_transparent;

    sprite_rom_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(LAT), .KEY_COLOR(KEY)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_addr_i(req_addr),
        .gnt_o(gnt), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
        .rsp_transparent_o(rsp_transparent)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: a few fixed pixels, the rest derived from the address
    function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
        case (a)
            19'd100: rom_val = 24'h123456;
            19'd7:   rom_val = 24'hFF00FF;
            19'd8:   rom_val = 24'hFF00FE;
            default: rom_val = DW'({a, 5'b0}) ^ 24'h3C00A5 ^ DW'(a);
        endcase
    endfunction

    // Single-cycle synchronous ROM
    always @(posedge clk) rom_data <= rom_val(rom_addr);

    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            rr = 0;
    logic [N-1:0]  exp_gnt = '0;
    logic [AW-1:0] exp_addr = '0;
    int            gcount [N];

    function automatic logic [N*AW-1:0] mk(input int a0, input int a1, input int a2, input int a3);
        mk = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endfunction

    // Response monitor: pops expectations whenever the DUT presents output
    always @(negedge clk) begin
        if (rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: id=%0d data=%h required no response", rsp_id, rsp_data);
            end else begin
                e = sb.pop_front();
                if (int'(rsp_id) != e.id || rsp_data !== e.data ||
                    rsp_transparent !== (e.data == KEY) || cyc != e.due) begin
                    errors++;
                    $display("FAIL rsp: id=%0d data=%h transp=%0b cyc=%0d required id=%0d data=%h transp=%0b cyc=%0d",
                             rsp_id, rsp_data, rsp_transparent, cyc, e.id, e.data, (e.data == KEY), e.due);
                end
            end
        end else begin
            checks++;
            if (rsp_transparent !== 1'b0 || rsp_id !== 2'd0) begin
                errors++;
                $display("FAIL rsp_idle: transp=%0b id=%0d required 0 and 0", rsp_transparent, rsp_id);
            end
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL rsp_missing: rsp_valid=0 required id=%0d data=%h at cyc %0d",
                         sb[0].id, sb[0].data, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    // One clock of stimulus; called at posedge+1, checks grant after next edge
    task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] av);
        int w;
        req      = r;
        req_addr = av;
        w = -1;
        for (int off = 0; off < int'(N); off++) begin
            if (w < 0 && r[(rr + off) % N]) w = (rr + off) % N;
        end
        if (w >= 0) begin
            exp_gnt  = '0;
            exp_gnt[w] = 1'b1;
            exp_addr = av[w*AW +: AW];
            rr       = (w + 1) % N;
            sb.push_back('{w, rom_val(exp_addr), cyc + 1 + LAT});
        end else begin
            exp_gnt = '0;
        end
        @(posedge clk); #1;
        checks++;
        if (gnt !== exp_gnt) begin
            errors++;
            $display("FAIL gnt: got %b required %b (cyc %0d)", gnt, exp_gnt, cyc);
        end
        checks++;
        if (rom_addr !== exp_addr) begin
            errors++;
            $display("FAIL rom_addr: got %0d required %0d (cyc %0d)", rom_addr, exp_addr, cyc);
        end
        for (int i = 0; i < int'(N); i++) gcount[i] += int'(gnt[i]);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req = '0;
        sb.delete();
        rr = 0;
        exp_gnt = '0;
        exp_addr = '0;
        repeat (n) @(posedge clk);
        #1;
        checks++;
        if (gnt !== '0 || rom_addr !== '0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b rom_addr=%0d required 0 and 0", gnt, rom_addr);
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] r;
        do_reset(2);

        // Idle after reset
        repeat (10) step('0, '0);

        // Fairness with everyone requesting
        for (int i = 0; i < int'(N); i++) gcount[i] = 0;
        repeat (8) step(4'b1111, mk(10, 20, 30, 40));
        for (int i = 0; i < int'(N); i++) begin
            checks++;
            if (gcount[i] != 2) begin
                errors++;
                $display("FAIL fairness: requester %0d granted %0d required 2", i, gcount[i]);
            end
        end
        step('0, '0);

        // Single fetch from requester 1
        step(4'b0010, mk(0, 100, 0, 0));
        repeat (3) step('0, mk(0, 100, 0, 0));

        // Pointer wrap 3 -> 0
        step(4'b0100, mk(1, 2, 3, 4));
        step(4'b1001, mk(500, 2, 3, 600));
        step(4'b1001, mk(501, 2, 3, 601));
        repeat (2) step('0, '0);

        // Transparency key vs near miss
        step(4'b0001, mk(7, 0, 0, 0));
        step('0, '0);
        step(4'b0001, mk(8, 0, 0, 0));
        repeat (3) step('0, '0);

        // Reset between grant and response drops the fetch and clears the pointer
        step(4'b0100, mk(0, 0, 55, 0));
        do_reset(1);
        step(4'b1111, mk(11, 22, 33, 44));
        repeat (3) step('0, '0);

        // Randomised traffic
        for (int t = 0; t < 400; t++) begin
            r = ($urandom_range(0, 3) == 0) ? N'(0) : N'($urandom_range(0, 15));
            step(r, {AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom)});
        end
        repeat (4) step('0, '0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
